// File: rtl/counter_seq_pkg.sv
// Shared constants for the counter command sequencer: FSM encoding, MODO codes, requester ids.
package counter_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] MODO_UP   = 2'b00;
    localparam logic [1:0] MODO_DN1  = 2'b01;
    localparam logic [1:0] MODO_DN3  = 2'b10;
    localparam logic [1:0] MODO_LOAD = 2'b11;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the last-grant pointer only moves when i_update is set.
module rr_arbiter2
    import counter_seq_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_update,
    output logic o_grant_a,
    output logic o_grant_b
);

    logic r_last;
    logic w_grant_a;
    logic w_grant_b;

    // On a tie the requester that was not served last wins.
    assign w_grant_a = i_req_a & (~i_req_b | (r_last == ID_B));
    assign w_grant_b = i_req_b & ~w_grant_a;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= ID_B;
        end else if (i_update && (w_grant_a || w_grant_b)) begin
            r_last <= w_grant_b ? ID_B : ID_A;
        end
    end

    assign o_grant_a = w_grant_a;
    assign o_grant_b = w_grant_b;

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Runs one load/count command at a time on the shared 4-bit mode counter for requesters A and B,
// returning final Q, a saturating RCO count and a load-error flag.
module counter_cmd_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned RCNT_W = 8
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              a_valid,
    input  logic [1:0]        a_mode,
    input  logic [3:0]        a_d,
    input  logic [LEN_W-1:0]  a_len,
    output logic              a_ack,
    input  logic              b_valid,
    input  logic [1:0]        b_mode,
    input  logic [3:0]        b_d,
    input  logic [LEN_W-1:0]  b_len,
    output logic              b_ack,
    input  logic [3:0]        Q,
    input  logic              RCO,
    input  logic              LOAD,
    output logic              ENABLE,
    output logic [1:0]        MODO,
    output logic [3:0]        D,
    output logic              busy,
    output logic              done,
    output logic              done_id,
    output logic [3:0]        q_final,
    output logic [RCNT_W-1:0] rco_cnt,
    output logic              load_err
);

    logic [1:0]        r_state;
    logic [1:0]        r_cmd_mode;
    logic              r_cmd_id;
    logic [LEN_W-1:0]  r_run_cnt;
    logic              r_first;
    logic              r_a_ack;
    logic              r_b_ack;
    logic              r_enable;
    logic [1:0]        r_modo;
    logic [3:0]        r_d;
    logic              r_busy;
    logic              r_done;
    logic              r_done_id;
    logic [3:0]        r_q_final;
    logic [RCNT_W-1:0] r_rco_cnt;
    logic              r_load_err;

    logic w_grant_a;
    logic w_grant_b;
    logic w_arb_update;

    assign w_arb_update = (r_state == ST_IDLE);

    rr_arbiter2 u_arb (
        .i_clk     (clk),
        .i_rst     (RESET),
        .i_req_a   (a_valid),
        .i_req_b   (b_valid),
        .i_update  (w_arb_update),
        .o_grant_a (w_grant_a),
        .o_grant_b (w_grant_b)
    );

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_cmd_mode <= MODO_UP;
            r_cmd_id   <= ID_A;
            r_run_cnt  <= '0;
            r_first    <= 1'b0;
            r_a_ack    <= 1'b0;
            r_b_ack    <= 1'b0;
            r_enable   <= 1'b0;
            r_modo     <= MODO_UP;
            r_d        <= 4'h0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_done_id  <= ID_A;
            r_q_final  <= 4'h0;
            r_rco_cnt  <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_a || w_grant_b) begin
                        r_state    <= ST_LOAD;
                        r_busy     <= 1'b1;
                        r_a_ack    <= w_grant_a;
                        r_b_ack    <= w_grant_b;
                        r_cmd_id   <= w_grant_b ? ID_B : ID_A;
                        r_cmd_mode <= w_grant_b ? b_mode : a_mode;
                        r_run_cnt  <= w_grant_b ? b_len : a_len;
                        r_d        <= w_grant_b ? b_d : a_d;
                        r_enable   <= 1'b1;
                        r_modo     <= MODO_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_rco_cnt  <= '0;
                    r_load_err <= 1'b0;
                    r_first    <= 1'b1;
                    if (r_cmd_mode != MODO_LOAD && r_run_cnt != '0) begin
                        r_state <= ST_RUN;
                        r_modo  <= r_cmd_mode;
                    end else begin
                        r_state  <= ST_DONE;
                        r_enable <= 1'b0;
                        r_modo   <= MODO_UP;
                    end
                end
                ST_RUN: begin
                    // First RUN cycle checks the load; later cycles see RCO from the previous step.
                    r_first <= 1'b0;
                    if (r_first) begin
                        r_load_err <= ~LOAD;
                    end else if (RCO && r_rco_cnt != '1) begin
                        r_rco_cnt <= r_rco_cnt + RCNT_W'(1);
                    end
                    r_run_cnt <= r_run_cnt - LEN_W'(1);
                    if (r_run_cnt == LEN_W'(1)) begin
                        r_state  <= ST_DONE;
                        r_enable <= 1'b0;
                        r_modo   <= MODO_UP;
                    end
                end
                ST_DONE: begin
                    // r_first still set means RUN was skipped, so no count step produced an RCO.
                    if (r_first) begin
                        r_load_err <= ~LOAD;
                    end else if (RCO && r_rco_cnt != '1) begin
                        r_rco_cnt <= r_rco_cnt + RCNT_W'(1);
                    end
                    r_first   <= 1'b0;
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_done_id <= r_cmd_id;
                    r_q_final <= Q;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign a_ack    = r_a_ack;
    assign b_ack    = r_b_ack;
    assign ENABLE   = r_enable;
    assign MODO     = r_modo;
    assign D        = r_d;
    assign busy     = r_busy;
    assign done     = r_done;
    assign done_id  = r_done_id;
    assign q_final  = r_q_final;
    assign rco_cnt  = r_rco_cnt;
    assign load_err = r_load_err;

endmodule
